// File: rtl/seg_pkg.sv
// Purpose: shared constants for the seven-segment scan driver (modes, glyph codes, FSM states).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seg_pkg;

  // Display mode encodings; 2'b11 is not listed and is treated as hex.
  localparam logic [1:0] MODE_HEX  = 2'b00;
  localparam logic [1:0] MODE_UDEC = 2'b01;
  localparam logic [1:0] MODE_SDEC = 2'b10;

  // 5-bit glyph codes held in the display registers. GL_0..GL_F equal their
  // nibble value, so a hex or BCD nibble becomes a glyph by zero-extension.
  localparam logic [4:0] GL_0     = 5'd0;
  localparam logic [4:0] GL_1     = 5'd1;
  localparam logic [4:0] GL_2     = 5'd2;
  localparam logic [4:0] GL_3     = 5'd3;
  localparam logic [4:0] GL_4     = 5'd4;
  localparam logic [4:0] GL_5     = 5'd5;
  localparam logic [4:0] GL_6     = 5'd6;
  localparam logic [4:0] GL_7     = 5'd7;
  localparam logic [4:0] GL_8     = 5'd8;
  localparam logic [4:0] GL_9     = 5'd9;
  localparam logic [4:0] GL_A     = 5'd10;
  localparam logic [4:0] GL_B     = 5'd11;
  localparam logic [4:0] GL_C     = 5'd12;
  localparam logic [4:0] GL_D     = 5'd13;
  localparam logic [4:0] GL_E     = 5'd14;
  localparam logic [4:0] GL_F     = 5'd15;
  localparam logic [4:0] GL_BLANK = 5'd16;
  localparam logic [4:0] GL_MINUS = 5'd17;
  localparam logic [4:0] GL_R     = 5'd18;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } state_e;

  function automatic logic is_dec(input logic [1:0] m);
    return (m == MODE_UDEC) || (m == MODE_SDEC);
  endfunction

  // Double-dabble nibble correction applied before each shift.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/seg_glyph_rom.sv
// Purpose: combinational glyph code -> segment pattern lookup.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: code (5-bit glyph code in), seg (7-bit {a,b,c,d,e,f,g} active-high out).
module seg_glyph_rom
  import seg_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b0000000;
    case (code)
      GL_0:     seg = 7'b1111110;
      GL_1:     seg = 7'b0110000;
      GL_2:     seg = 7'b1101101;
      GL_3:     seg = 7'b1111001;
      GL_4:     seg = 7'b0110011;
      GL_5:     seg = 7'b1011011;
      GL_6:     seg = 7'b1011111;
      GL_7:     seg = 7'b1110000;
      GL_8:     seg = 7'b1111111;
      GL_9:     seg = 7'b1111011;
      GL_A:     seg = 7'b1110111;
      GL_B:     seg = 7'b0011111;
      GL_C:     seg = 7'b1001110;
      GL_D:     seg = 7'b0111101;
      GL_E:     seg = 7'b1001111;
      GL_F:     seg = 7'b1000111;
      GL_R:     seg = 7'b0000101;
      GL_MINUS: seg = 7'b0000001;
      default:  seg = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/seg_scan_display.sv
// Purpose: multiplexed 7-seg driver; captures a value on load, converts (hex / unsigned / signed dec) and scans it out.
// Latency: hex/error glyphs visible 2 edges after load; decimal WIDTH+2 edges (serial double-dabble).
// Backpressure: busy=1 during conversion; a load while busy is dropped, never queued.
// Ports: clk, rst_n (async active-low); value/mode/error sampled with load; busy out;
//        seg_out[7:1]={a..g} active-high, seg_out[0]=dp (always 0); cs_out active-low one-hot, bit 0 = rightmost.
// Build option: define SEG_BLINK_EN to add a blink input that blanks all digits on alternate 32-frame periods.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 10000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  value,
  input  logic              load,
  input  logic [1:0]        mode,
  input  logic              error,
`ifdef SEG_BLINK_EN
  input  logic              blink,
`endif
  output logic              busy,
  output logic [7:0]        seg_out,
  output logic [DIGITS-1:0] cs_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int IDX_W = $clog2(DIGITS);
  localparam int RC_W  = $clog2(REFRESH_DIV);
  localparam int SC_W  = $clog2(WIDTH + 1);

  // ---------------------------------------------------------------------------
  // Conversion state
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   sh_q, sh_d;       // hex value, or decimal magnitude being shifted out
  logic [1:0]         mode_q, mode_d;
  logic               err_q, err_d;
  logic               neg_q, neg_d;
  logic [SC_W-1:0]    sc_q, sc_d;       // shift cycle count
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;     // sticky: a 1 fell off the top BCD nibble
  logic [4:0]         glyph_q [DIGITS];
  logic [4:0]         glyph_d [DIGITS];

  // ---------------------------------------------------------------------------
  // Scan state
  // ---------------------------------------------------------------------------
  logic [RC_W-1:0]    rcnt_q, rcnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         seg_q, seg_d;
  logic [DIGITS-1:0]  cs_q, cs_d;
`ifdef SEG_BLINK_EN
  logic [5:0]         frame_q, frame_d;
`endif

  logic [BCD_W-1:0]   bcd_adj;
  logic [4:0]         commit_glyph [DIGITS];
  logic [IDX_W-1:0]   msd;              // most significant nonzero BCD digit (0 if value is 0)
  logic               dec_ovf;
  logic               slot_wrap;
  logic               frame_wrap;
  logic [4:0]         cur_glyph;
  logic [6:0]         rom_seg;

  // ---------------------------------------------------------------------------
  // Glyphs to commit, derived from the finished conversion
  // ---------------------------------------------------------------------------
  always_comb begin
    msd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) msd = IDX_W'(i);
    end
    // A negative number using every digit leaves no room for its sign.
    dec_ovf = ovf_q || (neg_q && (msd == IDX_W'(DIGITS - 1)));

    for (int i = 0; i < DIGITS; i++) begin
      commit_glyph[i] = GL_BLANK;
      if (err_q) begin
        if (i == 0 || i == 1) commit_glyph[i] = GL_R;
        else if (i == 2)      commit_glyph[i] = GL_E;
      end else if (!is_dec(mode_q)) begin
        commit_glyph[i] = {1'b0, 4'(sh_q >> (4 * i))};
      end else if (dec_ovf) begin
        commit_glyph[i] = GL_MINUS;
      end else if (IDX_W'(i) <= msd) begin
        commit_glyph[i] = {1'b0, bcd_q[4*i +: 4]};
      end else if (neg_q && (i == int'(msd) + 1)) begin
        commit_glyph[i] = GL_MINUS;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Conversion FSM next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    mode_d  = mode_q;
    err_d   = err_q;
    neg_d   = neg_q;
    sc_d    = sc_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    for (int i = 0; i < DIGITS; i++) glyph_d[i] = glyph_q[i];

    bcd_adj = '0;
    for (int i = 0; i < DIGITS; i++) bcd_adj[4*i +: 4] = add3(bcd_q[4*i +: 4]);

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          mode_d  = mode;
          err_d   = error;
          neg_d   = (mode == MODE_SDEC) && value[WIDTH-1];
          // Two's-complement magnitude; the most-negative value maps to 2^(WIDTH-1).
          sh_d    = ((mode == MODE_SDEC) && value[WIDTH-1]) ? (~value) + WIDTH'(1) : value;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          sc_d    = '0;
          state_d = (error || !is_dec(mode)) ? ST_COMMIT : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bcd_d = {bcd_adj[BCD_W-2:0], sh_q[WIDTH-1]};
        sh_d  = sh_q << 1;
        ovf_d = ovf_q | bcd_adj[BCD_W-1];
        sc_d  = sc_q + SC_W'(1);
        if (sc_q == SC_W'(WIDTH - 1)) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        for (int i = 0; i < DIGITS; i++) glyph_d[i] = commit_glyph[i];
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Scan next-state: segments and select are both registered off idx_d, so
  // they switch together; a commit shows up on the next edge without restart.
  // ---------------------------------------------------------------------------
  always_comb begin
    slot_wrap  = (rcnt_q == RC_W'(REFRESH_DIV - 1));
    frame_wrap = slot_wrap && (idx_q == IDX_W'(DIGITS - 1));
    rcnt_d     = slot_wrap ? '0 : rcnt_q + RC_W'(1);
    idx_d      = idx_q;
    if (slot_wrap) idx_d = frame_wrap ? '0 : idx_q + IDX_W'(1);

    cur_glyph = glyph_q[idx_d];
    seg_d     = {rom_seg, 1'b0};
    cs_d      = ~(DIGITS'(1) << idx_d);
`ifdef SEG_BLINK_EN
    frame_d = frame_q + (frame_wrap ? 6'd1 : 6'd0);
    if (blink && frame_d[5]) cs_d = '1;
`endif
  end

  seg_glyph_rom u_glyph_rom (
    .code (cur_glyph),
    .seg  (rom_seg)
  );

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      sh_q    <= '0;
      mode_q  <= MODE_HEX;
      err_q   <= 1'b0;
      neg_q   <= 1'b0;
      sc_q    <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < DIGITS; i++) glyph_q[i] <= GL_BLANK;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      sh_q    <= sh_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      neg_q   <= neg_d;
      sc_q    <= sc_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < DIGITS; i++) glyph_q[i] <= glyph_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt_q  <= '0;
      idx_q   <= '0;
      seg_q   <= '0;
      cs_q    <= ~DIGITS'(1);
`ifdef SEG_BLINK_EN
      frame_q <= '0;
`endif
    end else begin
      rcnt_q  <= rcnt_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      cs_q    <= cs_d;
`ifdef SEG_BLINK_EN
      frame_q <= frame_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign seg_out = seg_q;
  assign cs_out  = cs_q;

endmodule

// File: tb/tb_seg_scan_display.sv
module tb_seg_scan_display;

  localparam int WIDTH       = 32;
  localparam int DIGITS      = 4;
  localparam int REFRESH_DIV = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] value = '0;
  logic        load  = 1'b0;
  logic [1:0]  mode  = 2'b00;
  logic        error = 1'b0;
`ifdef SEG_BLINK_EN
  logic        blink = 1'b0;
`endif
  logic        busy;
  logic [7:0]  seg_out;
  logic [3:0]  cs_out;

  int vectors     = 0;
  int miscompares = 0;

  byte        exp_ch  [4];   // expected character per digit, index 0 = rightmost
  logic [6:0] obs_seg [4];
  logic       dp_seen;
  logic       cs_bad;

  seg_scan_display #(
    .WIDTH       (WIDTH),
    .DIGITS      (DIGITS),
    .REFRESH_DIV (REFRESH_DIV)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .value   (value),
    .load    (load),
    .mode    (mode),
    .error   (error),
`ifdef SEG_BLINK_EN
    .blink   (blink),
`endif
    .busy    (busy),
    .seg_out (seg_out),
    .cs_out  (cs_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Segment patterns {a..g} for each displayable character.
  function automatic logic [6:0] seg_of(input byte c);
    case (c)
      "0": return 7'b1111110;
      "1": return 7'b0110000;
      "2": return 7'b1101101;
      "3": return 7'b1111001;
      "4": return 7'b0110011;
      "5": return 7'b1011011;
      "6": return 7'b1011111;
      "7": return 7'b1110000;
      "8": return 7'b1111111;
      "9": return 7'b1111011;
      "A": return 7'b1110111;
      "B": return 7'b0011111;
      "C": return 7'b1001110;
      "D": return 7'b0111101;
      "E": return 7'b1001111;
      "F": return 7'b1000111;
      "r": return 7'b0000101;
      "-": return 7'b0000001;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic byte hex_ch(input int n);
    return (n < 10) ? byte'(48 + n) : byte'(65 + n - 10);
  endfunction

  // Reference model: what the 4-digit display should read for a load.
  task automatic model(input logic [31:0] v, input logic [1:0] m, input logic e);
    longint mag, p;
    bit     neg;
    int     nd;
    if (e) begin
      exp_ch[3] = " "; exp_ch[2] = "E"; exp_ch[1] = "r"; exp_ch[0] = "r";
    end else if (m == 2'b01 || m == 2'b10) begin
      neg = (m == 2'b10) && v[31];
      mag = neg ? (64'h1_0000_0000 - {32'd0, v}) : {32'd0, v};
      nd  = 1;
      p   = 10;
      while (mag >= p) begin nd++; p = p * 10; end
      if (mag > 9999 || (neg && nd >= 4)) begin
        for (int i = 0; i < 4; i++) exp_ch[i] = "-";
      end else begin
        p = 1;
        for (int i = 0; i < 4; i++) begin
          if (i < nd)               exp_ch[i] = byte'(48 + int'((mag / p) % 10));
          else if (neg && i == nd)  exp_ch[i] = "-";
          else                      exp_ch[i] = " ";
          p = p * 10;
        end
      end
    end else begin
      for (int i = 0; i < 4; i++) exp_ch[i] = hex_ch(int'(v[4*i +: 4]));
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Watch one full scan frame and record what each digit shows.
  task automatic capture();
    for (int i = 0; i < 4; i++) obs_seg[i] = 'x;
    dp_seen = 1'b0;
    cs_bad  = 1'b0;
    repeat (DIGITS * REFRESH_DIV) begin
      @(negedge clk);
      case (cs_out)
        4'b1110: obs_seg[0] = seg_out[7:1];
        4'b1101: obs_seg[1] = seg_out[7:1];
        4'b1011: obs_seg[2] = seg_out[7:1];
        4'b0111: obs_seg[3] = seg_out[7:1];
        default: cs_bad = 1'b1;
      endcase
      dp_seen = dp_seen | seg_out[0];
    end
  endtask

  task automatic check_display(input string tag);
    capture();
    for (int i = 0; i < 4; i++)
      check($sformatf("%s digit%0d", tag, i), {25'd0, obs_seg[i]}, {25'd0, seg_of(exp_ch[i])});
    check({tag, " dp"}, {31'd0, dp_seen}, 32'd0);
    check({tag, " cs_onehot"}, {31'd0, cs_bad}, 32'd0);
  endtask

  // Issue one load, count busy cycles, then check the displayed result.
  task automatic do_load(input logic [31:0] v, input logic [1:0] m, input logic e, input string tag);
    int nb;
    int exp_nb;
    model(v, m, e);
    value = v; mode = m; error = e; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    nb = 0;
    while (busy === 1'b1 && nb < 100) begin
      nb++;
      @(negedge clk);
    end
    exp_nb = (e || !(m == 2'b01 || m == 2'b10)) ? 1 : WIDTH + 1;
    check({tag, " busy_cycles"}, nb, exp_nb);
    check_display(tag);
  endtask

  initial begin
    int          nb;
    logic [3:0]  e_cs;
    logic [31:0] rv;
    logic [1:0]  rm;
    logic        re;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst cs", {28'd0, cs_out}, 32'h0000000e);
    check("rst seg", {24'd0, seg_out}, 32'd0);
    rst_n = 1'b1;

    // Free-running scan with blank display
    for (int n = 0; n < 16; n++) begin
      e_cs = 4'b0001 << ((n / 4) % 4);
      e_cs = ~e_cs;
      check($sformatf("scan cs t%0d", n), {28'd0, cs_out}, {28'd0, e_cs});
      check($sformatf("scan seg t%0d", n), {24'd0, seg_out}, 32'd0);
      @(negedge clk);
    end

    // Directed cases
    do_load(32'h0000BEEF, 2'b00, 1'b0, "hex_beef");
    do_load(32'd42,       2'b01, 1'b0, "udec_42");
    do_load(-32'sd7,      2'b10, 1'b0, "sdec_m7");
    do_load(-32'sd1234,   2'b10, 1'b0, "sdec_m1234");
    do_load(32'd10000,    2'b01, 1'b0, "udec_10000");
    do_load(32'd0,        2'b01, 1'b0, "udec_0");
    do_load(32'd9999,     2'b01, 1'b0, "udec_9999");
    do_load(-32'sd999,    2'b10, 1'b0, "sdec_m999");
    do_load(32'h80000000, 2'b10, 1'b0, "sdec_minneg");
    do_load(32'hFFFF1234, 2'b11, 1'b0, "mode11_hex");
    do_load(32'd1234,     2'b10, 1'b0, "sdec_pos1234");

    // Load while busy is dropped: result and busy length follow the first load
    model(32'd42, 2'b01, 1'b0);
    value = 32'd42; mode = 2'b01; error = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    nb = 0;
    while (busy === 1'b1 && nb < 100) begin
      nb++;
      if (nb == 5) begin value = 32'd99; mode = 2'b00; load = 1'b1; end
      else load = 1'b0;
      @(negedge clk);
    end
    load = 1'b0;
    check("ignored_load busy_cycles", nb, WIDTH + 1);
    check_display("ignored_load");

    // Reset mid-conversion aborts and blanks
    value = 32'd5678; mode = 2'b01; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (10) @(negedge clk);
    check("midshift busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midshift busy", {31'd0, busy}, 32'd0);
    check("midshift cs", {28'd0, cs_out}, 32'h0000000e);
    check("midshift seg", {24'd0, seg_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) exp_ch[i] = " ";
    check_display("after_reset");
    check("after_reset busy", {31'd0, busy}, 32'd0);

    // Error overrides the mode
    do_load(32'd42, 2'b01, 1'b1, "error");

    // Randomized loads
    for (int r = 0; r < 12; r++) begin
      rm = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: rv = $urandom_range(0, 99999);
        1: rv = 32'd0 - 32'($urandom_range(0, 2000));
        2: rv = $urandom;
        default: rv = $urandom_range(0, 9999);
      endcase
      re = ($urandom_range(0, 7) == 0);
      do_load(rv, rm, re, $sformatf("rand%0d v=%0h m=%0d e=%0d", r, rv, rm, re));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
